// File: rtl/cvbs_pkg.sv
// Shared constants, types and ROM-building helper for the NTSC composite encoder.
package cvbs_pkg;

  localparam int CVBS_W = 10;
  localparam int PH_W   = 10;

  localparam logic [31:0]       NTSC_PHASE_INC = 32'd569408543;
  localparam logic [CVBS_W-1:0] SYNC_LEVEL     = 10'd16;
  localparam logic [CVBS_W-1:0] BLANK_LEVEL    = 10'd240;
  localparam logic [7:0]        OB_ZERO        = 8'd128;

  typedef struct packed {
    logic sync;
    logic blank;
    logic burst;
  } strobe_t;

  typedef enum logic [1:0] {
    SEL_ACTIVE,
    SEL_BLANK,
    SEL_BURST,
    SEL_SYNC
  } out_sel_e;

  // Output source by priority: sync > burst > blank > active picture.
  function automatic out_sel_e out_select(input strobe_t s);
    if (s.sync)  return SEL_SYNC;
    if (s.burst) return SEL_BURST;
    if (s.blank) return SEL_BLANK;
    return SEL_ACTIVE;
  endfunction

  // round(127 * sin(2*pi*k/1024)) for the first quadrant, k = 0..255, evaluated at
  // elaboration with a Q30 Taylor series so the table needs no real arithmetic.
  function automatic logic [7:0] quarter_sin(input int unsigned k);
    longint th;
    longint term;
    longint sum;
    th   = (longint'(k) * 64'sd6746518852) >>> 10;
    term = th;
    sum  = th;
    for (int n = 1; n <= 6; n++) begin
      term = -((((term * th) >>> 30) * th) >>> 30) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return 8'((sum * 127 + (64'sd1 <<< 29)) >>> 30);
  endfunction

endpackage

// File: rtl/nco_sincos.sv
// Quarter-wave sine ROM producing registered sin(ph) and cos(ph + PHASE_OFS).
module nco_sincos
  import cvbs_pkg::*;
#(
  parameter logic [PH_W-1:0] PHASE_OFS = 10'd94
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PH_W-1:0]        ph,
  output logic signed [7:0]      sine,
  output logic signed [7:0]      cosine
);

  logic [7:0]      qtr [256];
  logic [PH_W-1:0] cos_ph;

  for (genvar k = 0; k < 256; k++) begin : g_rom
    localparam logic [7:0] ENTRY = quarter_sin(k);
    assign qtr[k] = ENTRY;
  end

  // Quadrants 1 and 3 mirror the table; their index 0 is the peak, which the
  // 256-entry table does not hold.
  function automatic logic signed [7:0] lookup(input logic [PH_W-1:0] p);
    logic [7:0] idx;
    logic [7:0] mag;
    idx = p[8] ? (8'd0 - p[7:0]) : p[7:0];
    mag = (p[8] && (p[7:0] == 8'd0)) ? 8'd127 : qtr[idx];
    return p[9] ? -$signed(mag) : $signed(mag);
  endfunction

  assign cos_ph = ph + PH_W'(256) + PHASE_OFS;

  // NOTE: the ROM is constant logic and needs no reset; only the output registers are cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sine   <= '0;
      cosine <= '0;
    end else begin
      sine   <= lookup(ph);
      cosine <= lookup(cos_ph);
    end
  end

endmodule

// File: rtl/yiq_to_cvbs.sv
// NTSC composite encoder: YIQ in, 10-bit CVBS code out with a fixed 4-clk latency.
module yiq_to_cvbs
  import cvbs_pkg::*;
#(
  parameter logic [31:0]     PHASE_INC    = NTSC_PHASE_INC,
  parameter logic [PH_W-1:0] PHASE_OFS    = 10'd94,
  parameter logic [9:0]      LUMA_GAIN    = 10'd560,
  parameter int              CHROMA_SHIFT = 4,
  parameter logic [7:0]      BURST_AMP    = 8'd80
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        y,
  input  logic [7:0]        i,
  input  logic [7:0]        q,
  input  logic              sync,
  input  logic              blank,
  input  logic              burst_en,
  input  logic              sc_reset,
  output logic [CVBS_W-1:0] cvbs,
  output logic              cvbs_sync
);

  logic [31:0]         acc;
  logic [7:0]          y1, y2;
  logic signed [8:0]   i1, q1, i2, q2;
  logic [PH_W-1:0]     ph1;
  strobe_t             s1, s2, s3;
  logic signed [7:0]   sine2, cos2, sine3;
  logic signed [16:0]  ic3, qs3;
  logic [9:0]          luma3;
  logic signed [17:0]  chroma, active;
  logic signed [15:0]  burst_dev;
  logic [CVBS_W-1:0]   next_cvbs;

  nco_sincos #(.PHASE_OFS(PHASE_OFS)) u_nco (
    .clk    (clk),
    .rst_n  (rst_n),
    .ph     (ph1),
    .sine   (sine2),
    .cosine (cos2)
  );

  // NOTE: every pipeline stage uses non-blocking assignments so each register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      y1    <= '0;
      i1    <= '0;
      q1    <= '0;
      ph1   <= '0;
      s1    <= '0;
      y2    <= '0;
      i2    <= '0;
      q2    <= '0;
      s2    <= '0;
      ic3   <= '0;
      qs3   <= '0;
      luma3 <= '0;
      sine3 <= '0;
      s3    <= '0;
    end else begin
      acc   <= sc_reset ? '0 : acc + PHASE_INC;
      y1    <= y;
      i1    <= 9'(i) - 9'(OB_ZERO);
      q1    <= 9'(q) - 9'(OB_ZERO);
      ph1   <= acc[31:32-PH_W];
      s1    <= '{sync: sync, blank: blank, burst: burst_en};
      y2    <= y1;
      i2    <= i1;
      q2    <= q1;
      s2    <= s1;
      ic3   <= 17'(i2) * 17'(cos2);
      qs3   <= 17'(q2) * 17'(sine2);
      luma3 <= 10'((18'(y2) * 18'(LUMA_GAIN)) >> 8);
      sine3 <= sine2;
      s3    <= s2;
    end
  end

  assign chroma    = (18'(ic3) + 18'(qs3)) >>> CHROMA_SHIFT;
  assign active    = $signed({8'd0, BLANK_LEVEL}) + $signed({8'd0, luma3}) + chroma;
  assign burst_dev = ($signed({8'd0, BURST_AMP}) * 16'(sine3)) >>> 7;

  // NOTE: next_cvbs gets a default before the case so no latch can be inferred.
  always_comb begin
    next_cvbs = BLANK_LEVEL;
    unique case (out_select(s3))
      SEL_SYNC:   next_cvbs = SYNC_LEVEL;
      SEL_BURST:  next_cvbs = BLANK_LEVEL - 10'(burst_dev);
      SEL_BLANK:  next_cvbs = BLANK_LEVEL;
      SEL_ACTIVE: begin
        if (active < 18'sd0)         next_cvbs = '0;
        else if (active > 18'sd1023) next_cvbs = '1;
        else                         next_cvbs = active[CVBS_W-1:0];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cvbs      <= BLANK_LEVEL;
      cvbs_sync <= 1'b0;
    end else begin
      cvbs      <= next_cvbs;
      cvbs_sync <= s3.sync;
    end
  end

endmodule

// File: tb/tb_yiq_to_cvbs.sv
// Self-checking bench for yiq_to_cvbs: sample-level model plus directed literal checks.
module tb_yiq_to_cvbs;

  localparam real         PI      = 3.14159265358979;
  localparam logic [31:0] INC     = 32'd569408543;
  localparam int          COS_OFS = 256 + 94;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] y = 8'd0, i = 8'd128, q = 8'd128;
  logic       sync = 1'b0, blank = 1'b0, burst_en = 1'b0, sc_reset = 1'b0;
  logic [9:0] cvbs;
  logic       cvbs_sync;

  int n_vec = 0;
  int n_bad = 0;

  yiq_to_cvbs dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .y         (y),
    .i         (i),
    .q         (q),
    .sync      (sync),
    .blank     (blank),
    .burst_en  (burst_en),
    .sc_reset  (sc_reset),
    .cvbs      (cvbs),
    .cvbs_sync (cvbs_sync)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int msin(input int p);
    real s;
    s = 127.0 * $sin(2.0 * PI * real'(p) / 1024.0);
    return (s >= 0.0) ? int'($floor(s + 0.5)) : -int'($floor(0.5 - s));
  endfunction

  // Expected {cvbs_sync, cvbs} for one input sample taken at NCO phase ph.
  function automatic int model_word(input int yv, iv, qv, input bit s, b, be, input int ph);
    int code, sn, cs, mix;
    sn = msin(ph);
    cs = msin((ph + COS_OFS) % 1024);
    if (s)       code = 16;
    else if (be) code = 240 - ((80 * sn) >>> 7);
    else if (b)  code = 240;
    else begin
      mix  = ((iv - 128) * cs + (qv - 128) * sn) >>> 4;
      code = 240 + ((yv * 560) >> 8) + mix;
      if (code < 0)    code = 0;
      if (code > 1023) code = 1023;
    end
    return (int'(s) << 10) | code;
  endfunction

  logic [31:0] m_acc = '0;
  int          exp_q[$];
  int          cur_exp = 240;
  bit          cmp_en = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc   = '0;
      exp_q   = '{240, 240, 240};
      cur_exp = 240;
    end else begin
      exp_q.push_back(model_word(int'(y), int'(i), int'(q), sync, blank, burst_en,
                                 int'(m_acc[31:22])));
      cur_exp = exp_q.pop_front();
      m_acc   = sc_reset ? 32'd0 : m_acc + INC;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cvbs_vs_model", longint'(cvbs), longint'(cur_exp & 1023));
      check("sync_vs_model", longint'(cvbs_sync), longint'(cur_exp >> 10));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input int yv, iv, qv, input bit s, b, be, sr);
    @(posedge clk);
    #1;
    y = 8'(yv); i = 8'(iv); q = 8'(qv);
    sync = s; blank = b; burst_en = be; sc_reset = sr;
  endtask

  task automatic span(input int n, output int mx, output int mn, output int n16);
    mx = 0; mn = 1023; n16 = 0;
    repeat (n) begin
      @(negedge clk);
      if (int'(cvbs) > mx) mx = int'(cvbs);
      if (int'(cvbs) < mn) mn = int'(cvbs);
      if (cvbs == 10'd16) n16++;
    end
  endtask

  initial begin
    int mx, mn, n16;

    check("msin_0", msin(0), 0);
    check("msin_128", msin(128), 90);
    check("msin_256", msin(256), 127);
    check("msin_768", msin(768), -127);

    // Reset held with random inputs.
    repeat (6) begin
      @(posedge clk);
      #1;
      y = 8'($urandom); i = 8'($urandom); q = 8'($urandom);
      sync = 1'($urandom); blank = 1'($urandom); burst_en = 1'($urandom); sc_reset = 1'($urandom);
    end
    @(negedge clk);
    check("reset_cvbs", cvbs, 240);
    check("reset_cvbs_sync", cvbs_sync, 0);
    cmp_en = 1'b1;

    // Release with sc_reset pulse, neutral gray for 1000 clks.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    y = 8'd128; i = 8'd128; q = 8'd128;
    sync = 1'b0; blank = 1'b0; burst_en = 1'b0; sc_reset = 1'b1;
    set_in(128, 128, 128, 0, 0, 0, 0);
    repeat (1000) @(posedge clk);
    #1;
    check("nco_phase_1000", longint'(m_acc), 64'd2472859928);
    check("gray_level", cvbs, 520);

    set_in(255, 128, 128, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    check("white_level", cvbs, 797);
    set_in(0, 128, 128, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    check("black_level", cvbs, 240);

    // Single-clk sync pulse inside blanking: exactly 4 clks of latency.
    set_in(200, 30, 220, 0, 1, 0, 0);
    repeat (5) @(posedge clk);
    set_in(200, 30, 220, 1, 1, 0, 0);
    set_in(200, 30, 220, 0, 1, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("sync_before", cvbs, 240);
    @(posedge clk);
    #1;
    check("sync_level", cvbs, 16);
    check("sync_flag", cvbs_sync, 1);
    @(posedge clk);
    #1;
    check("blank_after_sync", cvbs, 240);
    check("sync_flag_after", cvbs_sync, 0);

    // Burst inside blanking, phase aligned by sc_reset.
    set_in(77, 10, 250, 0, 1, 1, 1);
    set_in(77, 10, 250, 0, 1, 1, 0);
    repeat (4) @(posedge clk);
    #1;
    check("burst_phase0", cvbs, 240);
    @(posedge clk);
    #1;
    check("burst_second", cvbs, 182);
    span(68, mx, mn, n16);
    check("burst_peak_hi", longint'(mx >= 318 && mx <= 322), 1);
    check("burst_peak_lo", longint'(mn >= 158 && mn <= 162), 1);

    // Burst with blank low, sc_reset mid-burst restarts at phase 0.
    set_in(128, 128, 128, 0, 0, 1, 0);
    repeat (10) @(posedge clk);
    set_in(128, 128, 128, 0, 0, 1, 1);
    set_in(128, 128, 128, 0, 0, 1, 0);
    repeat (4) @(posedge clk);
    #1;
    check("burst_restart", cvbs, 240);
    repeat (20) @(posedge clk);

    // Saturation both ways.
    set_in(255, 255, 0, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    span(200, mx, mn, n16);
    check("sat_high_max", mx, 1023);
    set_in(0, 0, 255, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    span(200, mx, mn, n16);
    check("sat_low_min", mn, 0);

    // sync + burst together for 10 clks: sync wins on exactly 10 samples.
    set_in(128, 128, 128, 0, 1, 0, 0);
    repeat (6) @(posedge clk);
    set_in(128, 128, 128, 1, 0, 1, 0);
    fork
      span(30, mx, mn, n16);
      begin
        repeat (9) @(posedge clk);
        set_in(128, 128, 128, 0, 1, 0, 0);
      end
    join
    check("sync_burst_count", n16, 10);

    // Asynchronous reset mid-line during sync.
    set_in(128, 128, 128, 1, 0, 0, 0);
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_cvbs", cvbs, 240);
    check("async_reset_sync", cvbs_sync, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    y = 8'd255; i = 8'd128; q = 8'd128;
    sync = 1'b0; blank = 1'b0; burst_en = 1'b0; sc_reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_reset_c3", cvbs, 240);
    @(posedge clk);
    #1;
    check("post_reset_c4", cvbs, 797);

    repeat (5) @(posedge clk);
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
